// File: rtl/rrl_pipe_if.sv
// Handshake bundle for the pipelined rotate-right unit: operand side,
// result side and the busy indicator.
interface rrl_pipe_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_data, in_amt, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_amt, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/rrl_pipe.sv
// Four-stage pipelined rotate-right: stage k rotates by 2**k when amount bit k
// is set. Valid/ready at both ends with full backpressure and bubble collapse.
module rrl_pipe #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  rrl_pipe_if.slave    bus
);
  localparam int STAGES = AMT_W;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [AMT_W-1:0]  amt_q  [STAGES];
  logic [AMT_W-1:0]  amt_d  [STAGES];

  // What each stage would load: stage 0 from the input port, others from below.
  logic [STAGES-1:0] src_vld;
  logic [WIDTH-1:0]  src_data [STAGES];
  logic [AMT_W-1:0]  src_amt  [STAGES];
  logic [STAGES-1:0] free;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  always_comb begin
    src_vld[0]  = bus.in_valid;
    src_data[0] = bus.in_data;
    src_amt[0]  = bus.in_amt;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k]  = vld_q[k-1];
      src_data[k] = data_q[k-1];
      src_amt[k]  = amt_q[k-1];
    end
  end

  // A stage may load when it is empty or its entry moves on; that reduces to
  // "out_ready, or some stage at/after k is empty", so no combinational loop.
  always_comb begin
    logic full_tail;
    full_tail = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_tail = full_tail & vld_q[k];
      free[k]   = !full_tail | bus.out_ready;
    end
  end

  always_comb begin
    // NOTE: every next-state signal starts from its held value so that no
    // path through this block leaves it unassigned and infers a latch.
    vld_d  = vld_q;
    data_d = data_q;
    amt_d  = amt_q;
    for (int k = 0; k < STAGES; k++) begin
      if (free[k]) begin
        vld_d[k] = src_vld[k];
        if (src_vld[k]) begin
          data_d[k] = src_amt[k][k] ? rotr(src_data[k], 1 << k) : src_data[k];
          amt_d[k]  = src_amt[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: payload registers are cleared too, because out_data must read
      // zero during reset; a plain datapath would normally reset only vld.
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      amt_q  <= amt_d;
    end
  end

  assign bus.in_ready  = free[0];
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];
  assign bus.busy      = |vld_q;
endmodule

// File: tb/tb_rrl_pipe.sv
// Self-checking bench for rrl_pipe: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_rrl_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rrl_pipe_if #(.WIDTH(16), .AMT_W(4)) bus ();
  rrl_pipe #(.WIDTH(16), .AMT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_out    = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Reference rotate: low half of the doubled word shifted right.
  function automatic logic [15:0] model_rotr(input logic [15:0] x, input int a);
    logic [31:0] dbl;
    dbl = {x, x} >> a;
    return dbl[15:0];
  endfunction

  // Entries in flight = accepted minus delivered; busy and in_ready follow.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", bus.busy, exp_q.size() != 0);
      check("in_ready", bus.in_ready, !(exp_q.size() == 4 && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        check("out_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("out_data", bus.out_data, exp_q.pop_front());
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model_rotr(bus.in_data, int'(bus.in_amt)));
    end
  end

  // All driving tasks start and end at posedge+1.
  task automatic send(input logic [15:0] d, input logic [3:0] a, output int waits);
    bit ok;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_valid = 1'b1;
    waits = 0;
    ok    = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      waits++;
      ok = bus.in_ready;
    end
    if (!ok) check("send_timeout", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic get_out(output logic [15:0] d);
    bit ok;
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        d  = bus.out_data;
      end
    end
    if (!ok) check("out_timeout", bus.out_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [15:0] t2_d[4]   = '{16'h8001, 16'hBEEF, 16'h0001, 16'hF00F};
  logic [3:0]  t2_a[4]   = '{4'd1, 4'd0, 4'd15, 4'd8};
  logic [15:0] t2_e[4]   = '{16'hC000, 16'hBEEF, 16'h0002, 16'h0FF0};
  logic [15:0] t4_d[4]   = '{16'h1234, 16'h0F0F, 16'hABCD, 16'h8000};
  logic [3:0]  t4_a[4]   = '{4'd4, 4'd1, 4'd3, 4'd15};

  initial begin
    int          w;
    int          total;
    int          out0;
    logic [15:0] got;
    bit          done;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_amt   = '0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single entry, exact latency and single-cycle result.
    send(16'h1234, 4'd4, w);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("t1_out_valid_c%0d", i), bus.out_valid, i == 4);
      if (i == 4) check("t1_out_data", bus.out_data, 16'h4123);
    end
    @(posedge clk); #1;

    // 2: edge amounts.
    for (int i = 0; i < 4; i++) begin
      send(t2_d[i], t2_a[i], w);
      get_out(got);
      check($sformatf("t2_vec%0d", i), got, t2_e[i]);
    end

    // 3: streaming, one accepted per cycle.
    total = 0;
    for (int i = 0; i < 16; i++) begin
      send(16'hA5C3, 4'(i), w);
      total += w;
    end
    check("t3_no_stall", total, 16);
    drain();

    // 4: backpressure with the pipe full.
    bus.out_ready = 1'b0;
    out0 = n_out;
    for (int i = 0; i < 4; i++) send(t4_d[i], t4_a[i], w);
    bus.in_data  = 16'h5555;
    bus.in_amt   = 4'd2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_in_ready_low", bus.in_ready, 0);
      check("t4_hold_valid", bus.out_valid, 1);
      check("t4_hold_data", bus.out_data, 16'h4123);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(16'h5555, 4'd2, w);
    drain();
    check("t4_drained_count", n_out - out0, 5);

    // 5: bubbles with random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send(16'($urandom), 4'($urandom_range(0, 15)), w);
          @(posedge clk); #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // 6: reset mid-flight.
    for (int i = 0; i < 3; i++) send(16'h1111 * 16'(i + 1), 4'(i + 1), w);
    #1 rst = 1'b1;
    bus.in_data  = 16'h00FF;
    bus.in_amt   = 4'd4;
    #1;
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_out_data", bus.out_data, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    #1 rst = 1'b0;
    send(16'h00FF, 4'd4, w);
    check("t6_first_accept", w, 1);
    get_out(got);
    check("t6_result", got, 16'hF00F);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
